// File: rtl/imm_encoder.sv
// imm_encoder: turns a full-width constant plus destination register into the
// MIPS instruction(s) that load it. Constants that survive a signed imm_size-bit
// round trip become a single ADDI; all others become LUI followed by ORI, one
// instruction per handshaked output beat.
//
// Optional build macro: IMM_ENC_LUI_SKIP_EN
//   When defined, an expansion whose low half is zero ends after the LUI beat
//   (LUI carries out_last=1 and no ORI is emitted). When undefined, ORI is
//   always emitted, even as ORI rt,rt,0x0000.
//
// state  | meaning
// IDLE   | waiting for a constant; in_ready=1
// SINGLE | presenting ADDI rt,$0,lo (final beat)
// HI     | presenting LUI rt,hi
// LO     | presenting ORI rt,rt,lo (final beat)

module imm_encoder #(
    parameter int size     = 32,
    parameter int imm_size = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [size-1:0]  in_value,
    input  logic [4:0]       in_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] expand_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SINGLE = 2'd1;
    localparam logic [1:0] HI     = 2'd2;
    localparam logic [1:0] LO     = 2'd3;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [size-1:0]     val_q;
    logic [4:0]          rt_q;
    logic                accept;
    logic                in_fits;
    logic [size-imm_size:0] top_bits;
    logic [imm_size-1:0] hi_half;
    logic [imm_size-1:0] lo_half;
    logic                lo_zero;

    // A constant fits when every bit from the sign bit of the immediate upward
    // is identical, i.e. sign extension of the low half reproduces it.
    assign top_bits = in_value[size-1:imm_size-1];
    assign in_fits  = (&top_bits) | ~(|top_bits);

    assign hi_half  = val_q[size-1:imm_size];
    assign lo_half  = val_q[imm_size-1:0];
    assign lo_zero  = (lo_half == '0);

    // in_ready depends only on the registered state, never on out_ready.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_ready & in_valid;

    // Next-state selection and per-state output beat.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_instr = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = in_fits ? SINGLE : HI;
                end
            end
            SINGLE: begin
                out_valid = 1'b1;
                out_instr = {OP_ADDI, 5'd0, rt_q, lo_half};
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            HI: begin
                out_valid = 1'b1;
                out_instr = {OP_LUI, 5'd0, rt_q, hi_half};
`ifdef IMM_ENC_LUI_SKIP_EN
                out_last  = lo_zero;
                if (out_ready) begin
                    state_nxt = lo_zero ? IDLE : LO;
                end
`else
                out_last  = 1'b0;
                if (out_ready) begin
                    state_nxt = LO;
                end
`endif
            end
            LO: begin
                out_valid = 1'b1;
                out_instr = {OP_ORI, rt_q, rt_q, lo_half};
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifndef IMM_ENC_LUI_SKIP_EN
    // lo_zero only steers the LUI-skip path; keep it observed in the default build.
    logic unused_lo_zero;
    assign unused_lo_zero = lo_zero;
`endif

    // State register plus capture of the accepted constant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            val_q <= '0;
            rt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                val_q <= in_value;
                rt_q  <= in_rt;
            end
        end
    end

    // Count accepted constants that needed expansion; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            expand_count <= '0;
        end else if (accept && !in_fits && (expand_count != {CNT_W{1'b1}})) begin
            expand_count <= expand_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder. Expected instruction streams come from a
// reference model built from the MIPS field layout with plain arithmetic.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        busy;
    logic [15:0] expand_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    logic [31:0] got_i[$];
    logic        got_l[$];
    logic [31:0] exp_i[$];
    logic        exp_l[$];

    imm_encoder #(.size(32), .imm_size(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_last(out_last), .busy(busy), .expand_count(expand_count)
    );

    always #5 clk = ~clk;

    // Reference: what instructions load v into register r, appended to exp_*.
    function automatic void model(input logic [31:0] v, input logic [4:0] r);
        longint sv;
        longint hi;
        longint lo;
        longint rr;
        bit     skip;
        sv = longint'($signed(v));
        hi = longint'(v) / 65536;
        lo = longint'(v) % 65536;
        rr = longint'(r);
        if (sv >= -32768 && sv <= 32767) begin
            exp_i.push_back(32'(8 * 67108864 + rr * 65536 + lo));
            exp_l.push_back(1'b1);
        end else begin
            if (exp_cnt < 65535) exp_cnt++;
            skip = 1'b0;
`ifdef IMM_ENC_LUI_SKIP_EN
            skip = (lo == 0);
`endif
            exp_i.push_back(32'(15 * 67108864 + rr * 65536 + hi));
            exp_l.push_back(skip);
            if (!skip) begin
                exp_i.push_back(32'(13 * 67108864 + rr * 2097152 + rr * 65536 + lo));
                exp_l.push_back(1'b1);
            end
        end
    endfunction

    // Presents one constant and collects its output beats with out_ready=1.
    task automatic xfer(input logic [31:0] v, input logic [4:0] r);
        int  n;
        bit  done;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; in_value = v; in_rt = r; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_value = $urandom; in_rt = 5'($urandom);
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            if (out_valid) begin
                got_i.push_back(out_instr);
                got_l.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            @(posedge clk); #1; n++;
        end
        out_ready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout value=%h no final beat within 20 cycles", v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_value = '0; in_rt = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
        checks++; if (expand_count !== 16'd0) begin errors++; $display("FAIL rst_expand_count got=%0d exp=0", expand_count); end
        // Reset while the LUI beat is stalled.
        in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd9;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midhi_out_valid got=%b exp=1", out_valid); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_cnt = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (expand_count !== 16'd0) begin errors++; $display("FAIL midrst_expand_count got=%0d exp=0", expand_count); end
    endtask

    task automatic test_directed();
        logic [31:0] vals[7] = '{32'h00000005, 32'hFFFF8000, 32'h00007FFF, 32'h00008000,
                                 32'hFFFF7FFF, 32'hABCD0000, 32'h00000000};
        logic [4:0]  rts[7]  = '{5'd8, 5'd3, 5'd0, 5'd4, 5'd31, 5'd2, 5'd0};
        for (int k = 0; k < 7; k++) begin
            got_i.delete(); got_l.delete(); exp_i.delete(); exp_l.delete();
            model(vals[k], rts[k]);
            xfer(vals[k], rts[k]);
            checks++;
            if (got_i.size() != exp_i.size()) begin
                errors++; $display("FAIL dir_beats value=%h got=%0d exp=%0d", vals[k], got_i.size(), exp_i.size());
            end else begin
                for (int b = 0; b < exp_i.size(); b++) begin
                    checks++;
                    if (got_i[b] !== exp_i[b] || got_l[b] !== exp_l[b]) begin
                        errors++; $display("FAIL dir_beat value=%h beat=%0d got=%h/%b exp=%h/%b",
                                           vals[k], b, got_i[b], got_l[b], exp_i[b], exp_l[b]);
                    end
                end
            end
            checks++;
            if (expand_count !== 16'(exp_cnt)) begin
                errors++; $display("FAIL dir_expand_count value=%h got=%0d exp=%0d", vals[k], expand_count, exp_cnt);
            end
        end
    endtask

    task automatic test_expand_stall();
        exp_i.delete(); exp_l.delete();
        model(32'h12345678, 5'd9);
        in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd9; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_value = $urandom; in_rt = 5'($urandom);
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_i[0] || out_last !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hi cyc=%0d got v=%b i=%h l=%b r=%b exp v=1 i=%h l=0 r=0",
                                   c, out_valid, out_instr, out_last, in_ready, exp_i[0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if (out_instr !== exp_i[0] || out_last !== 1'b0) begin
            errors++; $display("FAIL stall_hi_release got=%h/%b exp=%h/0", out_instr, out_last, exp_i[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== exp_i[1] || out_last !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_lo got v=%b i=%h l=%b r=%b exp v=1 i=%h l=1 r=0",
                               out_valid, out_instr, out_last, in_ready, exp_i[1]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_done got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
        checks++;
        if (expand_count !== 16'(exp_cnt)) begin
            errors++; $display("FAIL stall_expand_count got=%0d exp=%0d", expand_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3] = '{32'h00000001, 32'h00010000, 32'h00000002};
        int  idx;
        int  n;
        bit  acc;
        got_i.delete(); got_l.delete(); exp_i.delete(); exp_l.delete();
        for (int k = 0; k < 3; k++) model(vals[k], 5'd7);
        idx = 0; n = 0; out_ready = 1'b1;
        while ((idx < 3 || busy) && n < 40) begin
            in_valid = (idx < 3);
            in_value = (idx < 3) ? vals[idx] : 32'h0;
            in_rt = 5'd7;
            #0;
            acc = in_ready && in_valid;
            if (out_valid) begin got_i.push_back(out_instr); got_l.push_back(out_last); end
            checks++;
            if (in_ready !== !busy) begin
                errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b busy=%b", n, in_ready, busy);
            end
            @(posedge clk); #1;
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (got_i.size() != exp_i.size()) begin
            errors++; $display("FAIL b2b_beats got=%0d exp=%0d", got_i.size(), exp_i.size());
        end else begin
            for (int b = 0; b < exp_i.size(); b++) begin
                checks++;
                if (got_i[b] !== exp_i[b] || got_l[b] !== exp_l[b]) begin
                    errors++; $display("FAIL b2b_beat beat=%0d got=%h/%b exp=%h/%b", b, got_i[b], got_l[b], exp_i[b], exp_l[b]);
                end
            end
        end
        checks++;
        if (expand_count !== 16'(exp_cnt)) begin
            errors++; $display("FAIL b2b_expand_count got=%0d exp=%0d", expand_count, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [4:0]  r;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = {{16{1'b0}}, 16'($urandom)};
                2: v = {{16{1'b1}}, 16'($urandom)};
                default: v = {16'($urandom), 16'h0000};
            endcase
            r = 5'($urandom);
            got_i.delete(); got_l.delete(); exp_i.delete(); exp_l.delete();
            model(v, r);
            xfer(v, r);
            checks++;
            if (got_i.size() != exp_i.size()) begin
                errors++; $display("FAIL rnd_beats value=%h got=%0d exp=%0d", v, got_i.size(), exp_i.size());
            end else begin
                for (int b = 0; b < exp_i.size(); b++) begin
                    checks++;
                    if (got_i[b] !== exp_i[b] || got_l[b] !== exp_l[b]) begin
                        errors++; $display("FAIL rnd_beat value=%h beat=%0d got=%h/%b exp=%h/%b",
                                           v, b, got_i[b], got_l[b], exp_i[b], exp_l[b]);
                    end
                end
            end
            checks++;
            if (expand_count !== 16'(exp_cnt)) begin
                errors++; $display("FAIL rnd_expand_count value=%h got=%0d exp=%0d", v, expand_count, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_expand_stall();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
